// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: turns a simple valid/ready command stream into
// single AXI-lite read or write transactions, one outstanding at a time, and
// returns the result on a valid/ready response stream. A per-transaction
// cycle counter enforces an optional completion deadline. A late responder
// after a timeout is drained before the next command is accepted.
`timescale 1ns/1ps

module axil_cmd_master #(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                cmd_wdata,
    input  logic [3:0]                 cmd_wstrb,
    input  logic                       cmd_we,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    output logic [31:0]                rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic                       rsp_timeout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]                 m_axil_awprot,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [31:0]                m_axil_wdata,
    output logic [3:0]                 m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic [1:0]                 m_axil_bresp,
    input  logic                       m_axil_bvalid,
    output logic                       m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [31:0]                m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DRAIN,
        RESP
    } state_t;

    // The counter saturates at 16 bits, so deadlines above 65536 never fire.
    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

    state_t state, state_next;

    logic [AXIL_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                wdata_q;
    logic [3:0]                 wstrb_q;
    logic                       awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [15:0]                cnt_q;
    logic                       rsp_valid_q, rsp_timeout_q;
    logic [31:0]                rsp_rdata_q;
    logic [1:0]                 rsp_resp_q;

    logic        accept;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        aw_left, w_left;
    logic        in_txn;
    logic [16:0] cnt_inc;
    logic        timeout_hit;
    logic        load_b, load_r, load_to;
    logic        any_pending;

    assign cmd_ready   = (state == IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign aw_hs       = awvalid_q && m_axil_awready;
    assign w_hs        = wvalid_q && m_axil_wready;
    assign b_hs        = bready_q && m_axil_bvalid;
    assign ar_hs       = arvalid_q && m_axil_arready;
    assign r_hs        = rready_q && m_axil_rvalid;
    assign aw_left     = awvalid_q && !m_axil_awready;
    assign w_left      = wvalid_q && !m_axil_wready;
    assign any_pending = awvalid_q || wvalid_q || bready_q || arvalid_q || rready_q;
    assign in_txn      = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                         (state == RD_ADDR) || (state == RD_DATA);
    assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
    // The deadline fires on the edge at which the counter would reach the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_txn && (cnt_inc >= TIMEOUT_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; a completing handshake takes priority over the deadline.
    always_comb begin
        state_next = state;
        load_b     = 1'b0;
        load_r     = 1'b0;
        load_to    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = cmd_we ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: begin
                if (timeout_hit) begin
                    state_next = RESP;
                    load_to    = 1'b1;
                end else if (!aw_left && !w_left) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_next = RESP;
                    load_b     = 1'b1;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    load_to    = 1'b1;
                end
            end
            RD_ADDR: begin
                if (timeout_hit) begin
                    state_next = RESP;
                    load_to    = 1'b1;
                end else if (ar_hs) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_next = RESP;
                    load_r     = 1'b1;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    load_to    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = rsp_timeout_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!any_pending) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command payload is captured on acceptance and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // Channel flags live apart from the state so they survive a timeout into drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if ((awvalid_q || wvalid_q) && !aw_left && !w_left) bready_q <= 1'b1;
            if (b_hs)  bready_q  <= 1'b0;
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_hs)  rready_q  <= 1'b0;
            if (accept) begin
                awvalid_q <= cmd_we;
                wvalid_q  <= cmd_we;
                arvalid_q <= !cmd_we;
            end
        end
    end

    // Saturating per-transaction cycle counter.
    always_ff @(posedge clk) begin
        if (rst)                               cnt_q <= '0;
        else if (accept)                       cnt_q <= '0;
        else if (in_txn && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
    end

    // Response register: loaded on completion or timeout, released by rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= 2'b00;
            rsp_rdata_q   <= '0;
        end else if (load_b) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= m_axil_bresp;
            rsp_rdata_q   <= '0;
        end else if (load_r) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= m_axil_rresp;
            rsp_rdata_q   <= m_axil_rdata;
        end else if (load_to) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_resp_q    <= 2'b10;
            rsp_rdata_q   <= '0;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_rdata      = rsp_rdata_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: a cycle-stepped AXI-lite responder with
// programmable wait states, a table of directed transactions, hand-written
// reset sequences, and randomized transactions checked against a latency /
// response model derived from the responder's configured delays.
`timescale 1ns/1ps

module tb_axil_cmd_master;

    localparam int AW = 16;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          cmd_we, cmd_valid, cmd_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout, rsp_valid, rsp_ready;
    logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]    m_axil_awprot, m_axil_arprot;
    logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [31:0]   m_axil_wdata, m_axil_rdata;
    logic [3:0]    m_axil_wstrb;
    logic [1:0]    m_axil_bresp, m_axil_rresp;
    logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic          m_axil_rvalid, m_axil_rready;

    axil_cmd_master #(.AXIL_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_we(cmd_we), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_wait, w_wait, b_wait, ar_wait, r_wait, rdy_wait;
        logic [1:0]  resp_in;
        logic [31:0] rdata_in;
        bit          exp_to;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Responder configuration and bookkeeping.
    int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0]    cfg_bresp, cfg_rresp;
    logic [31:0]   cfg_rdata;
    int            aw_seen, w_seen, b_seen, ar_seen, r_seen;
    bit            aw_got, w_got, b_owed, r_owed, b_hs_prev, r_hs_prev;
    bit            aw_stall, w_stall, ar_stall, axi_bad;
    logic [AW-1:0] last_awaddr, last_araddr, cap_awaddr, cap_araddr;
    logic [31:0]   last_wdata, cap_wdata;
    logic [3:0]    last_wstrb, cap_wstrb;
    int            n_aw, n_w, n_b, n_ar, n_r;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                    m_axil_rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata});
    endfunction

    task automatic responder_clear();
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0;
        aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
        aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0; b_hs_prev = 0; r_hs_prev = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0; axi_bad = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        cap_awaddr = 'x; cap_araddr = 'x; cap_wdata = 'x; cap_wstrb = 'x;
    endtask

    // One responder decision per cycle, made at the falling edge for the next rising edge.
    task automatic responder_tick();
        if (b_hs_prev) m_axil_bvalid = 0;
        if (r_hs_prev) m_axil_rvalid = 0;
        if (b_owed && !m_axil_bvalid) begin
            if (b_seen >= b_wait) begin m_axil_bvalid = 1; m_axil_bresp = cfg_bresp; end
            else b_seen++;
        end
        b_hs_prev = m_axil_bvalid && m_axil_bready;
        if (b_hs_prev) begin n_b++; b_owed = 0; end
        if (r_owed && !m_axil_rvalid) begin
            if (r_seen >= r_wait) begin
                m_axil_rvalid = 1; m_axil_rresp = cfg_rresp; m_axil_rdata = cfg_rdata;
            end else r_seen++;
        end
        r_hs_prev = m_axil_rvalid && m_axil_rready;
        if (r_hs_prev) begin n_r++; r_owed = 0; end
        if (aw_stall && (!m_axil_awvalid || m_axil_awaddr !== last_awaddr)) axi_bad = 1;
        if (w_stall && (!m_axil_wvalid || m_axil_wdata !== last_wdata || m_axil_wstrb !== last_wstrb)) axi_bad = 1;
        if (ar_stall && (!m_axil_arvalid || m_axil_araddr !== last_araddr)) axi_bad = 1;
        if ((m_axil_awvalid && m_axil_awprot != 3'b000) || (m_axil_arvalid && m_axil_arprot != 3'b000)) axi_bad = 1;
        m_axil_awready = m_axil_awvalid && (aw_seen >= aw_wait);
        if (m_axil_awvalid) begin
            if (m_axil_awready) begin n_aw++; cap_awaddr = m_axil_awaddr; aw_got = 1; aw_seen = 0; end
            else aw_seen++;
        end
        m_axil_wready = m_axil_wvalid && (w_seen >= w_wait);
        if (m_axil_wvalid) begin
            if (m_axil_wready) begin
                n_w++; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb; w_got = 1; w_seen = 0;
            end else w_seen++;
        end
        m_axil_arready = m_axil_arvalid && (ar_seen >= ar_wait);
        if (m_axil_arvalid) begin
            if (m_axil_arready) begin n_ar++; cap_araddr = m_axil_araddr; r_owed = 1; r_seen = 0; ar_seen = 0; end
            else ar_seen++;
        end
        if (aw_got && w_got) begin b_owed = 1; b_seen = 0; aw_got = 0; w_got = 0; end
        aw_stall = m_axil_awvalid && !m_axil_awready; last_awaddr = m_axil_awaddr;
        w_stall  = m_axil_wvalid && !m_axil_wready;   last_wdata = m_axil_wdata; last_wstrb = m_axil_wstrb;
        ar_stall = m_axil_arvalid && !m_axil_arready; last_araddr = m_axil_araddr;
    endtask

    task automatic step();
        responder_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = 0; rsp_ready = 0;
        responder_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    // Expected outcome from the responder's delays: completion lands k edges after acceptance.
    function automatic vec_t model(input vec_t v);
        int k;
        k = v.we ? (((v.aw_wait > v.w_wait) ? v.aw_wait : v.w_wait) + v.b_wait + 2)
                 : (v.ar_wait + v.r_wait + 2);
        v.exp_to    = (k > T);
        v.exp_lat   = v.exp_to ? T : k;
        v.exp_resp  = v.exp_to ? 2'b10 : v.resp_in;
        v.exp_rdata = (v.exp_to || v.we) ? 32'd0 : v.rdata_in;
        return v;
    endfunction

    function automatic vec_t mk(bit we, logic [15:0] addr, logic [31:0] wdata, logic [3:0] strb,
                                int aw_w, int w_w, int b_w, int ar_w, int r_w, int rdy,
                                logic [1:0] resp_in, logic [31:0] rdata_in,
                                bit exp_to, logic [1:0] exp_resp, logic [31:0] exp_rdata, int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.aw_wait = aw_w; v.w_wait = w_w; v.b_wait = b_w; v.ar_wait = ar_w; v.r_wait = r_w;
        v.rdy_wait = rdy; v.resp_in = resp_in; v.rdata_in = rdata_in;
        v.exp_to = exp_to; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Runs one full command/response exchange, including any drain, and checks it.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   lat, waitc;
        logic busy_ok;
        logic [34:0] held;
        responder_clear();
        aw_wait = v.aw_wait; w_wait = v.w_wait; b_wait = v.b_wait;
        ar_wait = v.ar_wait; r_wait = v.r_wait;
        cfg_bresp = v.resp_in; cfg_rresp = v.resp_in; cfg_rdata = v.rdata_in;
        cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        cmd_valid = 1; rsp_ready = 0;
        checkOutput({tag, " cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.strb;
        busy_ok = 1; lat = 0;
        while (!rsp_valid && lat < 60) begin
            if (cmd_ready) busy_ok = 0;
            step();
            lat++;
        end
        checkOutput({tag, " rsp_latency"}, 64'(lat), 64'(v.exp_lat));
        checkOutput({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
        checkOutput({tag, " rsp_resp"}, 64'(rsp_resp), 64'(v.exp_resp));
        checkOutput({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        held = {rsp_timeout, rsp_resp, rsp_rdata};
        for (int i = 0; i < v.rdy_wait; i++) begin
            if (cmd_ready || !rsp_valid || {rsp_timeout, rsp_resp, rsp_rdata} !== held) busy_ok = 0;
            step();
        end
        rsp_ready = 1;
        if (cmd_ready || !rsp_valid || {rsp_timeout, rsp_resp, rsp_rdata} !== held) busy_ok = 0;
        step();
        rsp_ready = 0;
        checkOutput({tag, " busy_hold"}, 64'(busy_ok), 64'd1);
        checkOutput({tag, " rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        waitc = 0;
        while (!cmd_ready && waitc < 80) begin
            step();
            waitc++;
        end
        if (v.exp_to) checkOutput({tag, " drain_done"}, 64'(waitc < 80), 64'd1);
        else          checkOutput({tag, " idle_gap"}, 64'(waitc), 64'd0);
        checkOutput({tag, " beats"}, 64'({n_aw[7:0], n_w[7:0], n_b[7:0], n_ar[7:0], n_r[7:0]}),
                    v.we ? 64'h0101010000 : 64'h0000000101);
        if (v.we) checkOutput({tag, " wr_payload"}, 64'({cap_awaddr, cap_wdata, cap_wstrb}),
                              64'({v.addr, v.wdata, v.strb}));
        else      checkOutput({tag, " rd_payload"}, 64'(cap_araddr), 64'(v.addr));
        checkOutput({tag, " axi_rules"}, 64'(axi_bad), 64'd0);
        if (waitc >= 80) do_reset();
    endtask

    // Overall time bound in case the design stops advancing entirely.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed table, reset mid-read, randomized traffic.
    initial begin
        vec_t tbl[12];
        vec_t v;
        rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
        responder_clear();
        @(negedge clk);
        checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("reset outputs", out_vec(), 64'd0);
        rst = 0;
        #1;
        checkOutput("post_reset cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);

        tbl[0]  = mk(1, 16'h0024, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, 10, 2'b00, 32'h0,         0, 2'b00, 32'h0,         2);
        tbl[1]  = mk(0, 16'h0000, 32'h0,         4'h0, 0, 0, 0, 3, 2, 0,  2'b00, 32'h294E_C110, 0, 2'b00, 32'h294E_C110, 7);
        tbl[2]  = mk(1, 16'h0100, 32'hDEAD_BEEF, 4'h3, 0, 4, 0, 0, 0, 1,  2'b00, 32'h0,         0, 2'b00, 32'h0,         6);
        tbl[3]  = mk(1, 16'h0104, 32'h0123_4567, 4'hC, 4, 0, 0, 0, 0, 0,  2'b00, 32'h0,         0, 2'b00, 32'h0,         6);
        tbl[4]  = mk(0, 16'h0200, 32'h0,         4'h0, 0, 0, 0, 0, 30, 2, 2'b00, 32'hCAFE_F00D, 1, 2'b10, 32'h0,         8);
        tbl[5]  = mk(0, 16'h0204, 32'h0,         4'h0, 0, 0, 0, 3, 3, 0,  2'b01, 32'h1234_5678, 0, 2'b01, 32'h1234_5678, 8);
        tbl[6]  = mk(0, 16'h0208, 32'h0,         4'h0, 0, 0, 0, 3, 4, 0,  2'b00, 32'h8765_4321, 1, 2'b10, 32'h0,         8);
        tbl[7]  = mk(1, 16'h0300, 32'hA5A5_5A5A, 4'h1, 1, 1, 1, 0, 0, 0,  2'b10, 32'h0,         0, 2'b10, 32'h0,         4);
        tbl[8]  = mk(1, 16'h0304, 32'h0F0F_F0F0, 4'hF, 9, 0, 0, 0, 0, 3,  2'b00, 32'h0,         1, 2'b10, 32'h0,         8);
        tbl[9]  = mk(0, 16'hFFFC, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0,  2'b11, 32'h55AA_33CC, 0, 2'b11, 32'h55AA_33CC, 2);
        tbl[10] = mk(1, 16'h0400, 32'h0000_0001, 4'h1, 2, 0, 4, 0, 0, 0,  2'b01, 32'h0,         0, 2'b01, 32'h0,         8);
        tbl[11] = mk(1, 16'h0404, 32'h0000_0002, 4'h2, 0, 0, 7, 0, 0, 1,  2'b00, 32'h0,         1, 2'b10, 32'h0,         8);
        for (int i = 0; i < 12; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        // Reset while the read is waiting in RD_DATA: everything returns to reset values at once.
        responder_clear();
        ar_wait = 0; r_wait = 30; cfg_rresp = 0; cfg_rdata = 32'h1111_2222;
        cmd_we = 0; cmd_addr = 16'h0040; cmd_valid = 1;
        step();
        cmd_valid = 0;
        step();
        step();
        checkOutput("mid_rd rready_before_reset", 64'(m_axil_rready), 64'd1);
        rst = 1;
        responder_clear();
        @(negedge clk);
        checkOutput("mid_rd reset outputs", out_vec(), 64'd0);
        checkOutput("mid_rd cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
        rst = 0;
        #1;
        checkOutput("mid_rd cmd_ready_after", 64'(cmd_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            v.we       = 1'($urandom_range(0, 1));
            v.addr     = 16'($urandom) & 16'hFFFC;
            v.wdata    = $urandom;
            v.strb     = 4'($urandom);
            v.aw_wait  = $urandom_range(0, 4);
            v.w_wait   = $urandom_range(0, 4);
            v.b_wait   = $urandom_range(0, 4);
            v.ar_wait  = $urandom_range(0, 4);
            v.r_wait   = $urandom_range(0, 4);
            v.rdy_wait = $urandom_range(0, 3);
            v.resp_in  = 2'($urandom);
            v.rdata_in = $urandom;
            v = model(v);
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter AXIL_ADDR_WIDTH, default 16, the width of AXI-lite addresses and of cmd_addr.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024; completion deadline in clk cycles after command acceptance; 0 disables the timeout.
REQ-003 SHALL have ports, one clock, synchronous active-high reset:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  cmd_addr  in  AXIL_ADDR_WIDTH  byte address
  cmd_wdata  in  32  write data
  cmd_wstrb  in  4  write byte strobes
  cmd_we  in  1  1 = write, 0 = read
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
  rsp_rdata  out  32  read data (0 for writes/timeouts)
  rsp_resp  out  2  AXI response code
  rsp_timeout  out  1  transaction exceeded TIMEOUT_CYCLES
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
  m_axil_awaddr / m_axil_awprot / m_axil_awvalid  out  AXIL_ADDR_WIDTH / 3 / 1  AW channel
  m_axil_awready  in  1  AW accept
  m_axil_wdata / m_axil_wstrb / m_axil_wvalid  out  32 / 4 / 1  W channel
  m_axil_wready  in  1  W accept
  m_axil_bresp / m_axil_bvalid  in  2 / 1  B channel; m_axil_bready out 1
  m_axil_araddr / m_axil_arprot / m_axil_arvalid  out  AXIL_ADDR_WIDTH / 3 / 1  AR channel
  m_axil_arready  in  1  AR accept
  m_axil_rdata / m_axil_rresp / m_axil_rvalid  in  32 / 2 / 1  R channel; m_axil_rready out 1

Function
REQ-004 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DRAIN, RESP; exactly one transaction outstanding.
REQ-005 SHALL drive cmd_ready=1 only in IDLE; all other states 0.
REQ-006 On accepted write SHALL register addr/data/strb and, next cycle, enter WR_ADDR_DATA with awvalid=wvalid=1.
REQ-007 In WR_ADDR_DATA awvalid and wvalid SHALL each drop the cycle after their own handshake, in any order; once both done, enter WR_RESP with bready=1.
REQ-008 On accepted read SHALL enter RD_ADDR with arvalid=1 until arready, then RD_DATA with rready=1.
REQ-009 valid signals SHALL stay asserted and payload stable until handshake (AXI rule); awprot=arprot=3'b000 constant.
REQ-010 On B handshake SHALL capture bresp, rsp_rdata=0; on R handshake SHALL capture rdata and rresp; then enter RESP; rsp_valid=1 the cycle after the handshake.
REQ-011 In RESP rsp_valid and rsp_* SHALL hold stable until rsp_ready; on rsp_ready return to IDLE; cmd_ready=1 the following cycle (no same-cycle accept).
REQ-012 A 16-bit saturating cycle counter SHALL clear on acceptance and increment each cycle in WR_*/RD_* states.
REQ-013 If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES without completion SHALL enter RESP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-014 Completion handshake in the same cycle as timeout SHALL win (normal response, rsp_timeout=0).
REQ-015 After timeout, outstanding AXI valids/readies SHALL persist; once the response is consumed, FSM SHALL enter DRAIN and finish remaining handshakes, discarding B/R data, then IDLE; cmd_ready=0 throughout DRAIN.
REQ-016 Non-OKAY bresp/rresp SHALL pass through unchanged with rsp_timeout=0.

Reset
REQ-017 On rst SHALL go to IDLE; cmd_ready=0 during rst cycle, 1 after; all m_axil valid/ready, rsp_valid, rsp_timeout =0; rsp_rdata, rsp_resp, counter =0.
REQ-018 rst mid-transaction SHALL abandon it immediately without drain; responder is reset by the same rst.

Verification
REQ-019 Write 0x24, data 0x0000_00A5, strb 0xF, zero-wait responder -> one AW+W beat with those values, rsp_resp=00, rsp_valid 1 cycle after B handshake.
REQ-020 Read 0x00, responder returns 0x294E_C110 after 3 wait cycles on arready and 2 on rvalid -> rsp_rdata=0x294E_C110, rsp_resp=00.
REQ-021 Write with awready 4 cycles before wready, then reversed -> each valid drops individually, exactly one B accepted.
REQ-022 TIMEOUT_CYCLES=8, responder never asserts rvalid -> rsp_timeout=1, rsp_resp=10 at cycle 8; after late rvalid, DRAIN completes, cmd_ready returns.
REQ-023 rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0; rst asserted mid-RD_DATA -> all outputs at reset values next cycle.
